// File: rtl/rendering_drv_pkg.sv
// Shared types and widths for the rendering stream driver.
package rendering_drv_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LEN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rendering_drv_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only
// when a pop frees the slot in the same cycle.
module rendering_drv_fifo #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = rendering_drv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    dout     = mem[rd_ptr_q];
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/rendering_stream_driver.sv
// Drives a batch of buffered words into the rendering pipeline and captures the
// frame-buffer words it returns, with an idle watchdog that aborts a stuck run.
module rendering_stream_driver
  import rendering_drv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic [LEN_W-1:0]  rx_len,
  input  logic              ld_wr_en,
  input  logic [DATA_W-1:0] ld_wr_data,
  output logic              ld_full,
  output logic [DATA_W-1:0] Output_1_V_TDATA,
  output logic              Output_1_V_TVALID,
  input  logic              Output_1_V_TREADY,
  input  logic [DATA_W-1:0] Input_1_V_TDATA,
  input  logic              Input_1_V_TVALID,
  output logic              Input_1_V_TREADY,
  output logic              cap_vld,
  output logic [LEN_W-1:0]  cap_addr,
  output logic [DATA_W-1:0] cap_data,
  output logic              err_timeout
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  tx_len_q, tx_len_d, rx_len_q, rx_len_d;
  logic [LEN_W-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [LEN_W-1:0]  tx_cnt_nxt, rx_cnt_nxt;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_q, err_d;
  logic              cap_vld_q, cap_vld_d;
  logic [LEN_W-1:0]  cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              tx_valid_c, rx_ready_c, tx_beat, rx_beat;
  logic              start_acc, run_complete, idle_expire, timeout_hit;

  rendering_drv_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (ld_wr_en),
    .din   (ld_wr_data),
    .full  (fifo_full),
    .pop   (tx_beat),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // Handshakes and run-termination conditions; completion beats timeout.
  always_comb begin
    tx_valid_c   = (state_q == RUN) && (tx_cnt_q != tx_len_q) && !fifo_empty;
    rx_ready_c   = (state_q == RUN) && (rx_cnt_q != rx_len_q);
    tx_beat      = tx_valid_c && Output_1_V_TREADY;
    rx_beat      = rx_ready_c && Input_1_V_TVALID;
    start_acc    = (state_q == IDLE) && ap_start;
    tx_cnt_nxt   = tx_beat ? tx_cnt_q + LEN_W'(1) : tx_cnt_q;
    rx_cnt_nxt   = rx_beat ? rx_cnt_q + LEN_W'(1) : rx_cnt_q;
    run_complete = (tx_cnt_nxt == tx_len_q) && (rx_cnt_nxt == rx_len_q);
    idle_expire  = (idle_q == IDLE_W'(TIMEOUT - 1)) && !tx_beat && !rx_beat;
    timeout_hit  = idle_expire && !run_complete;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ap_start) state_d = RUN;
      RUN:     if (run_complete || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ap_idle           = (state_q == IDLE);
    ap_done           = (state_q == DONE);
    ap_ready          = (state_q == DONE);
    ld_full           = fifo_full;
    Output_1_V_TVALID = tx_valid_c;
    Output_1_V_TDATA  = tx_valid_c ? fifo_dout : '0;
    Input_1_V_TREADY  = rx_ready_c;
    cap_vld           = cap_vld_q;
    cap_addr          = cap_addr_q;
    cap_data          = cap_data_q;
    err_timeout       = err_q;
  end

  // Counters, latched lengths, watchdog and capture register.
  always_comb begin
    tx_len_d   = tx_len_q;
    rx_len_d   = rx_len_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    idle_d     = idle_q;
    err_d      = err_q;
    cap_vld_d  = rx_beat;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    if (start_acc) begin
      tx_len_d = tx_len;
      rx_len_d = rx_len;
      tx_cnt_d = '0;
      rx_cnt_d = '0;
      idle_d   = '0;
      err_d    = 1'b0;
    end else if (state_q == RUN) begin
      tx_cnt_d = tx_cnt_nxt;
      rx_cnt_d = rx_cnt_nxt;
      idle_d   = (tx_beat || rx_beat) ? '0 : idle_q + IDLE_W'(1);
      if (timeout_hit) begin
        err_d = 1'b1;
      end
    end
    if (rx_beat) begin
      cap_addr_d = rx_cnt_q;
      cap_data_d = Input_1_V_TDATA;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tx_len_q   <= '0;
      rx_len_q   <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else begin
      tx_len_q   <= tx_len_d;
      rx_len_q   <= rx_len_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      cap_vld_q  <= cap_vld_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
    end
  end

endmodule

// File: tb/tb_rendering_stream_driver.sv
// Scoreboard bench for rendering_stream_driver: loaded words and sourced words
// are queued as expectations and retired against the tx stream and capture port.
module tb_rendering_stream_driver;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 16;
  localparam int unsigned TO    = 20;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready;
  logic [LW-1:0] tx_len = '0;
  logic [LW-1:0] rx_len = '0;
  logic          ld_wr_en = 1'b0;
  logic [31:0]   ld_wr_data = '0;
  logic          ld_full;
  logic [31:0]   Output_1_V_TDATA;
  logic          Output_1_V_TVALID;
  logic          Output_1_V_TREADY = 1'b0;
  logic [31:0]   Input_1_V_TDATA = '0;
  logic          Input_1_V_TVALID = 1'b0;
  logic          Input_1_V_TREADY;
  logic          cap_vld;
  logic [LW-1:0] cap_addr;
  logic [31:0]   cap_data;
  logic          err_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_beats, cap_cnt, last_beat_cyc, done_cyc, idle_run, done_idle_run;
  bit done_seen;
  logic [31:0]        tx_q[$];
  logic [31:0]        src_q[$];
  logic [LW+31:0]     cap_q[$];
  logic [31:0]        held;

  rendering_stream_driver #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LW),
    .TIMEOUT    (TO)
  ) dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (ap_rst_n),
    .ap_start          (ap_start),
    .ap_done           (ap_done),
    .ap_idle           (ap_idle),
    .ap_ready          (ap_ready),
    .tx_len            (tx_len),
    .rx_len            (rx_len),
    .ld_wr_en          (ld_wr_en),
    .ld_wr_data        (ld_wr_data),
    .ld_full           (ld_full),
    .Output_1_V_TDATA  (Output_1_V_TDATA),
    .Output_1_V_TVALID (Output_1_V_TVALID),
    .Output_1_V_TREADY (Output_1_V_TREADY),
    .Input_1_V_TDATA   (Input_1_V_TDATA),
    .Input_1_V_TVALID  (Input_1_V_TVALID),
    .Input_1_V_TREADY  (Input_1_V_TREADY),
    .cap_vld           (cap_vld),
    .cap_addr          (cap_addr),
    .cap_data          (cap_data),
    .err_timeout       (err_timeout)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then update the upstream source.
  task automatic step();
    logic [31:0]    exp_w;
    logic [LW+31:0] exp_c;
    bit             rx_take;
    bit             beat;
    rx_take = 1'b0;
    beat    = 1'b0;
    @(negedge ap_clk);
    cyc++;
    if (ap_rst_n) begin
      if (Output_1_V_TVALID && Output_1_V_TREADY) begin
        tx_beats++;
        beat = 1'b1;
        if (tx_q.size() == 0) begin
          check_eq("tx_extra_beat", 64'(tx_q.size()), 64'(1));
        end else begin
          exp_w = tx_q.pop_front();
          check_eq("tx_data", 64'(Output_1_V_TDATA), 64'(exp_w));
        end
      end
      if (ld_wr_en && (tx_q.size() < DEPTH)) tx_q.push_back(ld_wr_data);
      if (Input_1_V_TVALID && Input_1_V_TREADY) begin
        rx_take = 1'b1;
        beat    = 1'b1;
      end
      if (beat) last_beat_cyc = cyc;
      if (!ap_idle && !ap_done) idle_run = beat ? 0 : idle_run + 1;
      if (cap_vld) begin
        cap_cnt++;
        if (cap_q.size() == 0) begin
          check_eq("cap_extra", 64'(cap_q.size()), 64'(1));
        end else begin
          exp_c = cap_q.pop_front();
          check_eq("cap_addr_data", 64'({cap_addr, cap_data}), 64'(exp_c));
        end
      end
      if (ap_done && !done_seen) begin
        done_seen     = 1'b1;
        done_cyc      = cyc;
        done_idle_run = idle_run;
        check_eq("ap_ready_with_done", 64'(ap_ready), 64'(1));
      end
    end
    @(posedge ap_clk);
    #1;
    if (rx_take && src_q.size() > 0) src_q.delete(0);
    Input_1_V_TVALID = (src_q.size() > 0);
    Input_1_V_TDATA  = (src_q.size() > 0) ? src_q[0] : 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_idle"},   64'(ap_idle), 64'(1));
    check_eq({tag, "_done"},   64'(ap_done), 64'(0));
    check_eq({tag, "_ready"},  64'(ap_ready), 64'(0));
    check_eq({tag, "_tvalid"}, 64'(Output_1_V_TVALID), 64'(0));
    check_eq({tag, "_tdata"},  64'(Output_1_V_TDATA), 64'(0));
    check_eq({tag, "_rxrdy"},  64'(Input_1_V_TREADY), 64'(0));
    check_eq({tag, "_cap"},    64'({cap_vld, cap_addr, cap_data}), 64'(0));
    check_eq({tag, "_err"},    64'(err_timeout), 64'(0));
    check_eq({tag, "_full"},   64'(ld_full), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    ld_wr_en = 1'b0;
    Input_1_V_TVALID = 1'b0;
    Input_1_V_TDATA  = '0;
    tx_q.delete();
    src_q.delete();
    cap_q.delete();
    #1;
    check_reset_outputs(tag);
    step();
    step();
    ap_rst_n = 1'b1;
    step();
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      ld_wr_en   = 1'b1;
      ld_wr_data = $urandom();
      step();
    end
    ld_wr_en = 1'b0;
  endtask

  task automatic add_src(input int n);
    for (int i = 0; i < n; i++) src_q.push_back($urandom());
  endtask

  task automatic start_run(input int txl, input int rxl);
    for (int i = 0; i < rxl && i < src_q.size(); i++) cap_q.push_back({LW'(i), src_q[i]});
    tx_len    = LW'(txl);
    rx_len    = LW'(rxl);
    ap_start  = 1'b1;
    done_seen = 1'b0;
    tx_beats  = 0;
    cap_cnt   = 0;
    idle_run  = 0;
    last_beat_cyc = cyc;
    step();
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!done_seen && n < max_cyc) begin
      step();
      n++;
    end
    check_eq({tag, "_done_reached"}, 64'(done_seen), 64'(1));
    step();
  endtask

  initial begin
    #1;
    // Reset values.
    do_reset("rst0");

    // Basic run: 6 tx words, 2 rx words, sink always ready.
    load_words(6);
    add_src(2);
    Output_1_V_TREADY = 1'b1;
    start_run(6, 2);
    wait_done("t1", 100);
    check_eq("t1_done_latency", 64'(done_cyc - last_beat_cyc), 64'(1));
    check_eq("t1_tx_beats", 64'(tx_beats), 64'(6));
    check_eq("t1_caps", 64'(cap_cnt), 64'(2));
    check_eq("t1_err", 64'(err_timeout), 64'(0));
    check_eq("t1_tx_left", 64'(tx_q.size()), 64'(0));

    // Sink back-pressure: data must hold and nothing is consumed.
    load_words(3);
    Output_1_V_TREADY = 1'b0;
    start_run(3, 0);
    held = Output_1_V_TDATA;
    check_eq("t2_valid_up", 64'(Output_1_V_TVALID), 64'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t2_valid_hold", 64'(Output_1_V_TVALID), 64'(1));
      check_eq("t2_data_hold", 64'(Output_1_V_TDATA), 64'(held));
    end
    check_eq("t2_no_beats", 64'(tx_beats), 64'(0));
    Output_1_V_TREADY = 1'b1;
    wait_done("t2", 50);
    check_eq("t2_tx_beats", 64'(tx_beats), 64'(3));

    // FIFO underrun stalls the run until more words arrive.
    load_words(2);
    start_run(4, 0);
    for (int i = 0; i < 10; i++) step();
    check_eq("t3_stall_beats", 64'(tx_beats), 64'(2));
    check_eq("t3_stall_valid", 64'(Output_1_V_TVALID), 64'(0));
    check_eq("t3_stall_busy", 64'(ap_idle), 64'(0));
    load_words(2);
    wait_done("t3", 50);
    check_eq("t3_tx_beats", 64'(tx_beats), 64'(4));
    check_eq("t3_err", 64'(err_timeout), 64'(0));

    // Watchdog abort after TO idle cycles, cleared by the next start.
    add_src(1);
    start_run(0, 3);
    wait_done("t4", 100);
    check_eq("t4_err", 64'(err_timeout), 64'(1));
    check_eq("t4_idle_cycles", 64'(done_idle_run), 64'(TO));
    check_eq("t4_caps", 64'(cap_cnt), 64'(1));
    start_run(0, 0);
    check_eq("t4_err_cleared", 64'(err_timeout), 64'(0));
    wait_done("t4b", 10);
    check_eq("t4b_err", 64'(err_timeout), 64'(0));

    // Surplus upstream words are back-pressured.
    add_src(5);
    start_run(0, 3);
    wait_done("t5", 50);
    for (int i = 0; i < 3; i++) step();
    check_eq("t5_caps", 64'(cap_cnt), 64'(3));
    check_eq("t5_rxrdy_low", 64'(Input_1_V_TREADY), 64'(0));
    check_eq("t5_src_left", 64'(src_q.size()), 64'(2));
    src_q.delete();
    step();

    // Reset in the middle of a run.
    load_words(4);
    add_src(3);
    Output_1_V_TREADY = 1'b0;
    start_run(4, 3);
    step();
    step();
    do_reset("t6_rst");

    // Fill the FIFO to DEPTH, one extra push dropped, then drain it in order.
    for (int i = 0; i < DEPTH; i++) begin
      load_words(1);
      if (i == DEPTH - 2) check_eq("t6_not_full", 64'(ld_full), 64'(0));
    end
    check_eq("t6_full", 64'(ld_full), 64'(1));
    load_words(1);
    check_eq("t6_full_after_drop", 64'(ld_full), 64'(1));
    Output_1_V_TREADY = 1'b1;
    start_run(DEPTH, 0);
    wait_done("t6", 100);
    check_eq("t6_tx_beats", 64'(tx_beats), 64'(DEPTH));
    check_eq("t6_drained_full", 64'(ld_full), 64'(0));
    check_eq("t6_err", 64'(err_timeout), 64'(0));

    // Nothing left behind: a one-word run must time out with no beat.
    start_run(1, 0);
    wait_done("t6e", 100);
    check_eq("t6e_no_beats", 64'(tx_beats), 64'(0));
    check_eq("t6e_err", 64'(err_timeout), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
